// File: rtl/mem_io_bridge_if.sv
// Core data-memory port bundle: core access, BRAM side, and UART TX/RX byte streams.
// master = core/BRAM/UART environment; slave = the bridge.
interface mem_io_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] mem_adr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      wea;
    logic            mem_re;
    logic            retire;
    logic [XLEN-1:0] din;
    logic [3:0]      dmem_we;
    logic [XLEN-1:0] dmem_rdata;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_ready;

    modport master (
        output mem_adr, mem_wdata, wea, mem_re, retire, dmem_rdata, tx_ready, rx_data, rx_valid,
        input  din, dmem_we, tx_data, tx_valid, rx_ready
    );

    modport slave (
        input  mem_adr, mem_wdata, wea, mem_re, retire, dmem_rdata, tx_ready, rx_data, rx_valid,
        output din, dmem_we, tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/mem_io_bridge.sv
// Data-memory bridge: routes core M-stage accesses to BRAM or MMIO (UART TX/RX, counters).
// Optional feature macro: MEM_IO_COUNTERS_EN enables the cycle/retired-instruction counters.
module mem_io_bridge #(
    parameter int XLEN     = 32,
    parameter int RX_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    mem_io_if.slave  bus
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RXD    = 8'h04;
    localparam logic [7:0] OFF_TXD    = 8'h08;
    localparam logic [7:0] OFF_CYC    = 8'h10;
    localparam logic [7:0] OFF_INS    = 8'h14;
    localparam logic [7:0] OFF_CLR    = 8'h18;

    logic       io_sel;
    logic [7:0] off;

    assign io_sel      = bus.mem_adr[31];
    assign off         = bus.mem_adr[7:0];
    assign bus.dmem_we = io_sel ? 4'b0000 : bus.wea;

    logic [7:0]    fifo_mem [RX_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign bus.rx_ready = ~full;
    assign push         = bus.rx_valid & ~full;
    assign pop          = bus.mem_re & io_sel & (off == OFF_RXD) & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= bus.rx_data;
    end

    logic       tx_vld;
    logic [7:0] tx_byte;
    logic       wr_tx;

    assign wr_tx        = io_sel & (off == OFF_TXD) & bus.wea[0];
    assign bus.tx_valid = tx_vld;
    assign bus.tx_data  = tx_byte;

    // Handshake has priority, so a store in the handshake cycle still sees tx_vld=1 and is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_vld  <= 1'b0;
            tx_byte <= 8'h00;
        end else if (tx_vld && bus.tx_ready) begin
            tx_vld  <= 1'b0;
        end else if (wr_tx && !tx_vld) begin
            tx_vld  <= 1'b1;
            tx_byte <= bus.mem_wdata[7:0];
        end
    end

    logic [31:0] cyc_rd;
    logic [31:0] ins_rd;

`ifdef MEM_IO_COUNTERS_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
    logic        wr_clr;

    assign wr_clr = io_sel & (off == OFF_CLR) & (bus.wea != 4'b0000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else if (wr_clr) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (bus.retire) instr_cnt <= instr_cnt + 32'd1;
        end
    end

    assign cyc_rd = cycle_cnt;
    assign ins_rd = instr_cnt;
`else
    logic unused_retire;

    assign unused_retire = bus.retire;
    assign cyc_rd        = 32'd0;
    assign ins_rd        = 32'd0;
`endif

    logic [XLEN-1:0] io_rd;

    always_comb begin
        io_rd = '0;
        case (off)
            OFF_STATUS: io_rd[1:0] = {~empty, ~tx_vld};
            OFF_RXD:    io_rd[7:0] = empty ? 8'h00 : fifo_mem[rd_ptr[AW-1:0]];
            OFF_CYC:    io_rd      = XLEN'(cyc_rd);
            OFF_INS:    io_rd      = XLEN'(ins_rd);
            default:    io_rd      = '0;
        endcase
    end

    // Stage p0 -> p1: capture source select and MMIO value alongside the BRAM read.
    logic            vld_p1;
    logic            sel_io_p1;
    logic [XLEN-1:0] io_p1;
    logic [XLEN-1:0] din_hold;
    logic [XLEN-1:0] din_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            sel_io_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.mem_re;
            if (bus.mem_re) sel_io_p1 <= io_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.mem_re) io_p1 <= io_rd;
    end

    // BRAM data only exists in the cycle after the read, so din is latched for hold cycles.
    assign din_p1  = vld_p1 ? (sel_io_p1 ? io_p1 : bus.dmem_rdata) : din_hold;
    assign bus.din = din_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) din_hold <= '0;
        else     din_hold <= din_p1;
    end

    logic unused_bits;

    assign unused_bits = ^{bus.mem_adr[XLEN-2:8], bus.mem_wdata[XLEN-1:8]};

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: queue/array reference model, directed scenarios then random traffic.
module tb_mem_io_bridge;
    localparam int XLEN     = 32;
    localparam int RX_DEPTH = 4;
`ifdef MEM_IO_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    mem_io_if #(.XLEN(XLEN)) bus ();

    mem_io_bridge #(.XLEN(XLEN), .RX_DEPTH(RX_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    // Behavioural BRAM attached to the DUT's dmem port.
    logic [31:0] bram [16];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (bus.dmem_we[i]) bram[bus.mem_adr[5:2]][i*8 +: 8] <= bus.mem_wdata[i*8 +: 8];
        bus.dmem_rdata <= bram[bus.mem_adr[5:2]];
    end

    // Reference model state
    logic [31:0] ref_mem [16];
    logic [7:0]  rx_q [$];
    logic [31:0] exp_q [$];
    logic        tx_pend;
    logic [7:0]  tx_byte;
    logic [31:0] m_cyc;
    logic [31:0] m_ins;

    // Monitor: checks din every cycle, popping an expectation when a read was issued.
    logic        re_d;
    logic [31:0] last_din;
    always @(posedge clk or posedge rst) begin
        if (rst) re_d <= 1'b0;
        else     re_d <= bus.mem_re;
    end

    always @(negedge clk) begin
        if (rst) begin
            last_din = 32'd0;
        end else if (re_d) begin
            if (exp_q.size() == 0) begin
                chk("din_queue_nonempty", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("din", bus.din, e);
                last_din = e;
            end
        end else begin
            chk("din_hold", bus.din, last_din);
        end
    end

    task automatic step(input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] we,
                        input logic re, input logic rxv, input logic [7:0] rxd,
                        input logic txr, input logic ret);
        logic [31:0] e;
        logic        io;
        logic [7:0]  off;
        int          sz;
        bus.mem_adr   = adr;
        bus.mem_wdata = wd;
        bus.wea       = we;
        bus.mem_re    = re;
        bus.rx_valid  = rxv;
        bus.rx_data   = rxd;
        bus.tx_ready  = txr;
        bus.retire    = ret;
        io  = adr[31];
        off = adr[7:0];
        sz  = rx_q.size();
        if (re) begin
            e = 32'd0;
            if (!io) e = ref_mem[adr[5:2]];
            else begin
                case (off)
                    8'h00: e = {30'd0, sz != 0, !tx_pend};
                    8'h04: e = (sz != 0) ? {24'd0, rx_q[0]} : 32'd0;
                    8'h10: e = CNT_EN ? m_cyc : 32'd0;
                    8'h14: e = CNT_EN ? m_ins : 32'd0;
                    default: e = 32'd0;
                endcase
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
        chk("dmem_we", {28'd0, bus.dmem_we}, io ? 32'd0 : {28'd0, we});
        chk("rx_ready", {31'd0, bus.rx_ready}, {31'd0, sz < RX_DEPTH});
        chk("tx_valid", {31'd0, bus.tx_valid}, {31'd0, tx_pend});
        chk("tx_data", {24'd0, bus.tx_data}, {24'd0, tx_byte});
        @(posedge clk);
        #1;
        if (!io)
            for (int i = 0; i < 4; i++)
                if (we[i]) ref_mem[adr[5:2]][i*8 +: 8] = wd[i*8 +: 8];
        if (re && io && off == 8'h04 && sz != 0) void'(rx_q.pop_front());
        if (rxv && sz < RX_DEPTH) rx_q.push_back(rxd);
        if (tx_pend && txr) tx_pend = 1'b0;
        else if (io && off == 8'h08 && we[0] && !tx_pend) begin
            tx_pend = 1'b1;
            tx_byte = wd[7:0];
        end
        if (io && off == 8'h18 && we != 4'd0) begin
            m_cyc = 32'd0;
            m_ins = 32'd0;
        end else begin
            m_cyc = m_cyc + 32'd1;
            if (ret) m_ins = m_ins + 32'd1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] adr);
        step(adr, 32'd0, 4'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] we);
        step(adr, wd, we, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic push_rx(input logic [7:0] b);
        step(32'd0, 32'd0, 4'd0, 1'b0, 1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input bit check_now);
        bus.mem_adr   = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.wea       = 4'd0;
        bus.mem_re    = 1'b0;
        bus.retire    = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'd0;
        bus.tx_ready  = 1'b0;
        rst = 1'b1;
        #1;
        if (check_now) begin
            chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
            chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
            chk("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
            chk("rst_din", bus.din, 32'd0);
        end
        rx_q.delete();
        tx_pend = 1'b0;
        tx_byte = 8'd0;
        m_cyc   = 32'd0;
        m_ins   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        logic [31:0] adr;
        logic [3:0]  we;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bram[i]    = 32'd0;
            ref_mem[i] = 32'd0;
        end
        do_reset(1'b0);
        chk("reset_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        chk("reset_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        chk("reset_din", bus.din, 32'd0);

        // BRAM store decode, then TX load of 0x41 with a stalled UART
        wr(32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
        wr(32'h8000_0008, 32'h0000_0041, 4'hF);
        chk("tx_valid_set", {31'd0, bus.tx_valid}, 32'd1);
        chk("tx_data_41", {24'd0, bus.tx_data}, 32'h41);
        rd(32'h0000_0100);
        wr(32'h8000_0008, 32'h0000_0042, 4'hF);
        chk("tx_drop_42", {24'd0, bus.tx_data}, 32'h41);
        step(32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        chk("tx_valid_clr", {31'd0, bus.tx_valid}, 32'd0);
        rd(32'h8000_0000);

        // RX FIFO fill, overflow attempt, drain and underflow read
        for (int i = 0; i < 4; i++) push_rx(8'(8'h11 * (i + 1)));
        chk("rx_full_ready", {31'd0, bus.rx_ready}, 32'd0);
        push_rx(8'h99);
        for (int i = 0; i < 5; i++) rd(32'h8000_0004);

        // Simultaneous push and pop with one entry held
        push_rx(8'h66);
        step(32'h8000_0004, 32'd0, 4'd0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        rd(32'h8000_0004);
        rd(32'h8000_0000);

        // Counters with retire every second cycle, then clear
        for (int i = 0; i < 100; i++) step(32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'(i % 2));
        rd(32'h8000_0010);
        rd(32'h8000_0014);
        wr(32'h8000_0018, 32'd0, 4'h1);
        rd(32'h8000_0010);
        rd(32'h8000_0010);
        rd(32'h8000_0014);

        // Reset with two FIFO entries and a pending TX byte
        push_rx(8'hA1);
        push_rx(8'hA2);
        wr(32'h8000_0008, 32'h0000_005A, 4'h1);
        idle(1);
        do_reset(1'b1);
        rd(32'h8000_0000);
        rd(32'h8000_0004);

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            logic rxv;
            logic txr;
            logic ret;
            rxv = ($urandom_range(0, 2) == 0);
            txr = ($urandom_range(0, 3) == 0);
            ret = 1'($urandom_range(0, 1));
            adr = 32'd0;
            we  = 4'd0;
            case ($urandom_range(0, 9))
                0: begin
                    adr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                    we  = 4'($urandom_range(1, 15));
                    step(adr, $urandom, we, 1'b0, rxv, 8'($urandom), txr, ret);
                end
                1, 2: begin
                    adr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                    step(adr, 32'd0, 4'd0, 1'b1, rxv, 8'($urandom), txr, ret);
                end
                3: step({1'b1, 23'($urandom), 8'h00}, 32'd0, 4'd0, 1'b1, rxv, 8'($urandom), txr, ret);
                4: step({1'b1, 23'($urandom), 8'h04}, 32'd0, 4'd0, 1'b1, rxv, 8'($urandom), txr, ret);
                5: step(32'h8000_0008, $urandom, 4'($urandom_range(0, 15)), 1'b0, rxv, 8'($urandom), txr, ret);
                6: step($urandom_range(0, 1) != 0 ? 32'h8000_0010 : 32'h8000_0014, 32'd0, 4'd0, 1'b1,
                        rxv, 8'($urandom), txr, ret);
                7: step(32'h8000_0018, 32'd0, 4'($urandom_range(0, 15)), 1'b0, rxv, 8'($urandom), txr, ret);
                8: begin
                    adr = {1'b1, 23'($urandom), 6'($urandom_range(8, 63)), 2'b00};
                    if ($urandom_range(0, 1) != 0)
                        step(adr, 32'd0, 4'd0, 1'b1, rxv, 8'($urandom), txr, ret);
                    else
                        step(adr, $urandom, 4'($urandom_range(1, 15)), 1'b0, rxv, 8'($urandom), txr, ret);
                end
                default: step(32'd0, 32'd0, 4'd0, 1'b0, rxv, 8'($urandom), txr, ret);
            endcase
        end
        idle(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
